rf_hazard_scoreboard: RTL

//  Read-side partner of the writeback control: tracks register-file writes in flight.

---
 rtl/cpu_isa_pkg.sv | 60 ++++++
 rtl/rf_pending_counter.sv | 29 ++
 rtl/rf_hazard_scoreboard.sv | 70 +++++++
 3 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA decode: opcode constants, register field positions and per-instruction
// register usage, so the ID scoreboard and WB control agree on which instructions write.
package cpu_isa_pkg;

  localparam int NREG   = 4;
  localparam int REG_W  = 2;
  localparam int CNT_W  = 2;
  localparam int PERF_W = 16;

  localparam int R1_LSB = 6;
  localparam int R2_LSB = 4;

  localparam logic [REG_W-1:0] ORI_REG = 2'd1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [3:0] OP_LOAD    = 4'b0000;
  localparam logic [3:0] OP_STORE   = 4'b0010;
  localparam logic [3:0] OP_NOP     = 4'b1010;
  localparam logic [2:0] OP_ORI_LO3 = 3'b111;

  typedef struct packed {
    logic [NREG-1:0]  src_mask;
    logic             has_dst;
    logic [REG_W-1:0] dst;
  } regs_t;

  // Priority order mirrors WB control: load, store, nop, ori, then the write-R1 default.
  function automatic regs_t decode_regs(input logic [7:0] ir);
    regs_t            d;
    logic [REG_W-1:0] r1;
    logic [REG_W-1:0] r2;
    logic [NREG-1:0]  m1;
    logic [NREG-1:0]  m2;
    logic [NREG-1:0]  mo;
    r1 = ir[R1_LSB +: REG_W];
    r2 = ir[R2_LSB +: REG_W];
    m1 = '0;
    m2 = '0;
    mo = '0;
    m1[r1] = 1'b1;
    m2[r2] = 1'b1;
    mo[ORI_REG] = 1'b1;
    d.src_mask = m1 | m2;
    d.has_dst  = 1'b1;
    d.dst      = r1;
    if (ir[3:0] == OP_LOAD) begin
      d.src_mask = m2;
    end else if (ir[3:0] == OP_STORE) begin
      d.has_dst = 1'b0;
    end else if (ir[3:0] == OP_NOP) begin
      d.src_mask = '0;
      d.has_dst  = 1'b0;
    end else if (ir[2:0] == OP_ORI_LO3) begin
      d.src_mask = mo;
      d.dst      = ORI_REG;
    end
    return d;
  endfunction

endpackage

// File: rtl/rf_pending_counter.sv
// In-flight write counter for one register; updates one cycle after inc/dec.
// Saturates at max and floors at zero; underflow flags a retire seen at zero.
module rf_pending_counter
  import cpu_isa_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         underflow
);

  assign underflow = dec & (count == '0);

  // Simultaneous inc and dec cancel; caller's max-stall keeps inc away from a full counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && count != '1) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/rf_hazard_scoreboard.sv
// Tracks register writes from ID issue to WB retire; stall is combinational from state.
// Stalls ID on pending sources or a full destination counter; no same-cycle WB bypass.
module rf_hazard_scoreboard
  import cpu_isa_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [7:0]        id_ir,
  input  logic              wb_valid,
  input  logic [7:0]        wb_ir,
  output logic              stall,
  output logic [NREG-1:0]   pending,
  output logic [PERF_W-1:0] stall_cycles,
  output logic              underflow_err
);

  regs_t                       id_d;
  regs_t                       wb_d;
  logic [NREG-1:0][CNT_W-1:0]  cnt;
  logic [NREG-1:0]             inc;
  logic [NREG-1:0]             dec;
  logic [NREG-1:0]             uflow;
  logic                        src_hazard;
  logic                        dst_full;
  logic                        issue;
  logic                        retire;

  assign id_d = decode_regs(id_ir);
  assign wb_d = decode_regs(wb_ir);

  // Pending reflects state only, so a source retiring this cycle still stalls.
  always_comb begin
    src_hazard = |(id_d.src_mask & pending);
    dst_full   = id_d.has_dst && (cnt[id_d.dst] == CNT_MAX);
    stall      = id_valid & (src_hazard | dst_full);
    issue      = id_valid & ~stall & id_d.has_dst;
    retire     = wb_valid & wb_d.has_dst;
  end

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    assign inc[r]     = issue  && (id_d.dst == REG_W'(r));
    assign dec[r]     = retire && (wb_d.dst == REG_W'(r));
    assign pending[r] = |cnt[r];

    rf_pending_counter #(.W(CNT_W)) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .inc       (inc[r]),
      .dec       (dec[r]),
      .count     (cnt[r]),
      .underflow (uflow[r])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles  <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (stall && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (|uflow) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule
